// File: rtl/regwb_pkg.sv
// Shared types and constants for the register writeback queue.
package regwb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int unsigned REGWB_DATA_W = 32;

  // One queued write at the register bank's native width.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   register;
    logic [REGWB_DATA_W-1:0] data;
  } regwb_entry_t;

endpackage

// File: rtl/regwb_bypass_cam.sv
// Read-port lookup over pending queue entries; returns the youngest matching write.
module regwb_bypass_cam
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic [REG_ADDR_W-1:0] regs_i [DEPTH],
  input  logic [DATA_W-1:0]     data_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [AW-1:0]         head_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  logic [AW-1:0] idx;

  // Scan oldest to youngest so the last match left standing is the freshest value.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + AW'(k);
      if (valid_i[idx] && (regs_i[idx] == addr_i) && (addr_i != REG_ZERO)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order write queue in front of the register bank write port.
// Optional read-side bypass of pending writes when REGWB_BYPASS_EN is defined.
module reg_writeback_queue
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [REG_ADDR_W-1:0] IN_REGISTER,
  input  logic [DATA_W-1:0]     IN_DATA,
  input  logic                  OUT_READY,
  output logic                  REG_WRITE,
  output logic [REG_ADDR_W-1:0] WRITE_REGISTER,
  output logic [DATA_W-1:0]     WRITE_DATA,
  input  logic [REG_ADDR_W-1:0] READ_REGISTER1,
  input  logic [REG_ADDR_W-1:0] READ_REGISTER2,
  output logic                  BYP_HIT1,
  output logic                  BYP_HIT2,
  output logic [DATA_W-1:0]     BYP_DATA1,
  output logic [DATA_W-1:0]     BYP_DATA2,
  output logic [CW-1:0]         PENDING
);

  logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [REG_ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic                  push, pop;

  always_comb begin
    REG_WRITE      = (count_q != '0);
    pop            = REG_WRITE && OUT_READY;
    // A full queue still accepts when the head drains in the same cycle.
    IN_READY       = RST_N && ((count_q < CW'(DEPTH)) || pop);
    // Writes to r0 complete the handshake but are dropped.
    push           = IN_VALID && IN_READY && (IN_REGISTER != REG_ZERO);
    WRITE_REGISTER = REG_WRITE ? reg_q[head_q] : REG_ZERO;
    WRITE_DATA     = REG_WRITE ? data_q[head_q] : '0;
    PENDING        = count_q;
    head_d         = pop  ? head_q + AW'(1) : head_q;
    tail_d         = push ? tail_q + AW'(1) : tail_q;
    count_d        = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      reg_q[tail_q]  <= IN_REGISTER;
      data_q[tail_q] <= IN_DATA;
    end
  end

`ifdef REGWB_BYPASS_EN
  logic [DEPTH-1:0] valid;

  always_comb begin : p_valid
    logic [AW-1:0] age;
    age   = '0;
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age      = AW'(i) - head_q;
      valid[i] = ({1'b0, age} < count_q);
    end
  end

  regwb_bypass_cam #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_cam1 (
    .regs_i  (reg_q),
    .data_i  (data_q),
    .valid_i (valid),
    .head_i  (head_q),
    .addr_i  (READ_REGISTER1),
    .hit_o   (BYP_HIT1),
    .data_o  (BYP_DATA1)
  );

  regwb_bypass_cam #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_cam2 (
    .regs_i  (reg_q),
    .data_i  (data_q),
    .valid_i (valid),
    .head_i  (head_q),
    .addr_i  (READ_REGISTER2),
    .hit_o   (BYP_HIT2),
    .data_o  (BYP_DATA2)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{READ_REGISTER1, READ_REGISTER2};
  assign BYP_HIT1  = 1'b0;
  assign BYP_HIT2  = 1'b0;
  assign BYP_DATA1 = '0;
  assign BYP_DATA2 = '0;
`endif

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side front end for the 32×32 register bank. It queues register write requests from result producers in a small FIFO, one {register, data} pair per entry. It drains them in order through the bank's single write port (WRITE_REGISTER / WRITE_DATA / REG_WRITE). Optionally it exposes pending values to the read side, so operands read during the drain window return the freshest data.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- DATA_W, 32: data width; must match the register bank
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  synchronous active-low reset, sampled on rising edge of CLK
- IN_VALID  input  1  producer has a write request
- IN_READY  output  1  queue accepts the request this cycle
- IN_REGISTER  input  5  destination register
- IN_DATA  input  DATA_W  value to write
- OUT_READY  input  1  register bank write port free this cycle
- REG_WRITE  output  1  head entry valid; drives the bank write enable
- WRITE_REGISTER  output  5  head entry register
- WRITE_DATA  output  DATA_W  head entry data
- READ_REGISTER1 / READ_REGISTER2  input  5  read-side addresses for bypass lookup
- BYP_HIT1 / BYP_HIT2  output  1  pending entry matches the address
- BYP_DATA1 / BYP_DATA2  output  DATA_W  youngest matching pending data
- PENDING  output  log2(DEPTH)+1  current entry count

## Operation
- Storage: circular buffer, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus an entry count.
- Push: occurs when IN_VALID && IN_READY && IN_REGISTER != 0.
  - A request to register 0 with IN_VALID && IN_READY is a handshake that completes but discards the data. Nothing is enqueued and the count is unchanged.
- Pop: occurs when REG_WRITE && OUT_READY. Head advances and the count decrements.
- IN_READY = (count < DEPTH) || (REG_WRITE && OUT_READY). When full, a push is allowed in the same cycle as a pop, and the count stays at DEPTH.
- Simultaneous push and pop at any count: count unchanged, both pointers advance.
- Empty with a push: no fall-through. REG_WRITE rises on the following cycle.
- REG_WRITE = (count != 0). WRITE_REGISTER / WRITE_DATA show the head entry, and are forced to 0 when empty.
- Order is strict FIFO. Repeated writes to the same register are each written in order; there is no coalescing.
- Data containing X or Z is enqueued unchanged; it is not filtered.
- Reset: count, pointers, PENDING, REG_WRITE, WRITE_REGISTER, WRITE_DATA, BYP_* are all 0, and IN_READY = 0 while RST_N = 0. Reset mid-drain discards every queued entry with no further writes.

## Timing
- Enqueue-to-write latency is 1 cycle when the queue is empty and OUT_READY = 1. A request accepted at edge k is written at edge k+1.
- Throughput is one push and one pop per cycle.
- IN_READY, REG_WRITE, WRITE_* and PENDING are functions of registered state and OUT_READY only. There is no path from IN_VALID to IN_READY.
- BYP_* are combinational from READ_REGISTERx and the stored entries. This includes the head entry being popped in the current cycle.

## Configuration
- REGWB_BYPASS_EN defined:
  - BYP_HITx = 1 when any valid entry has register == READ_REGISTERx and READ_REGISTERx != 0.
  - BYP_DATAx = data of the youngest such entry, else 0.
- REGWB_BYPASS_EN undefined:
  - Ports remain present; BYP_HITx and BYP_DATAx are tied to 0 and the comparators are not built.
  - READ_REGISTERx are unused.

## Structure
- Package regwb_pkg:
  - REG_ADDR_W = 5 and REG_ZERO = 5'd0
  - typedef regwb_entry_t {logic [4:0] register; logic [DATA_W-1:0] data;}
- Sub-module regwb_bypass_cam, instantiated twice, once per read port, only under REGWB_BYPASS_EN.
  - Given the entry array, valid mask and head pointer, it returns hit and youngest-match data.
- FIFO control stays in the top module.

## Test plan
- Reset, then push {r5, 0x0000_00AA} with OUT_READY=1 -> next cycle REG_WRITE=1, WRITE_REGISTER=5, WRITE_DATA=0xAA; the cycle after, REG_WRITE=0 and PENDING=0.
- OUT_READY=0 and push {r1,1},{r2,2},{r3,3},{r4,4} -> PENDING=4, IN_READY=0. Raise OUT_READY -> writes drain r1..r4 in order, one per cycle.
- Full queue, OUT_READY=1, IN_VALID=1 each cycle for 8 cycles -> IN_READY stays 1, PENDING stays 4, and 8 writes come out in order through the pointer wrap.
- Push {r0, 0xDEAD} -> IN_READY=1, PENDING stays 0, REG_WRITE never asserts.
- With REGWB_BYPASS_EN and OUT_READY=0, push {r7,0x11},{r7,0x22}, READ_REGISTER1=7, READ_REGISTER2=0 -> BYP_HIT1=1, BYP_DATA1=0x22, BYP_HIT2=0. Without the macro -> all BYP_* = 0.
- Push 3 entries with OUT_READY=0, then pull RST_N low for one cycle -> PENDING=0, REG_WRITE=0, no writes observed afterwards.
